// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter that runs one SRAM access at a time: a parameterised
// number of OE/WE cycles, then a one-cycle DONE/ack with the bus released.
module sram_access_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [1:0]    gnt,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          Mem_OE,
  output logic          Mem_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t        state_reg;
  logic [3:0]    wait_cnt_reg;
  logic          last_port_reg;
  logic          we_lat_reg;
  logic [1:0]    gnt_reg;
  logic [1:0]    ack_reg;
  logic [DW-1:0] rdata_reg;
  logic          mem_oe_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          sel_port_next;

  // On contention the port that did not win last time is served.
  always_comb begin
    sel_port_next = 1'b0;
    case (req)
      2'b10:   sel_port_next = 1'b1;
      2'b11:   sel_port_next = ~last_port_reg;
      default: sel_port_next = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      last_port_reg <= 1'b1;
      we_lat_reg    <= 1'b0;
      gnt_reg       <= '0;
      ack_reg       <= '0;
      rdata_reg     <= '0;
      mem_oe_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= '0;
          gnt_reg <= '0;
          if (req != 2'b00) begin
            // The SRAM address/data registers double as the latched request.
            gnt_reg       <= sel_port_next ? 2'b10 : 2'b01;
            last_port_reg <= sel_port_next;
            we_lat_reg    <= we[sel_port_next];
            mem_addr_reg  <= sel_port_next ? addr1 : addr0;
            mem_wdata_reg <= sel_port_next ? wdata1 : wdata0;
            mem_oe_reg    <= ~we[sel_port_next];
            mem_we_reg    <= we[sel_port_next];
            wait_cnt_reg  <= WAIT_LOAD;
            state_reg     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt_reg == 4'd0) begin
            mem_oe_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            ack_reg    <= gnt_reg;
            if (!we_lat_reg) begin
              rdata_reg <= MEM_RDATA;
            end
            state_reg <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        DONE: begin
          ack_reg   <= '0;
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_reg;
  assign gnt       = gnt_reg;
  assign rdata     = rdata_reg;
  assign busy      = (state_reg != IDLE);
  assign Mem_OE    = mem_oe_reg;
  assign Mem_WE    = mem_we_reg;
  assign MEM_ADDR  = mem_addr_reg;
  assign MEM_WDATA = mem_wdata_reg;

endmodule
